// File: rtl/rank_filter_pkg.sv
// Shared definitions for the 3x3 rank-order filter: mode encodings and pipeline depth.
package rank_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_BYPASS = 2'd3
  } rank_mode_e;

  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/rank_sort3.sv
// Registered three-input unsigned sorter (max/mid/min), one cycle of latency.
module rank_sort3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] mid_o,
  output logic [DATA_W-1:0] min_o
);

  logic [DATA_W-1:0] hi_ab, lo_ab;
  logic [DATA_W-1:0] max_d, mid_d, min_d;
  logic [DATA_W-1:0] max_q, mid_q, min_q;

  // Order a/b first, then place c relative to that pair.
  always_comb begin
    hi_ab = (a_i > b_i) ? a_i : b_i;
    lo_ab = (a_i > b_i) ? b_i : a_i;
    max_d = hi_ab;
    mid_d = c_i;
    min_d = lo_ab;
    if (c_i > hi_ab) begin
      max_d = c_i;
      mid_d = hi_ab;
    end else if (c_i < lo_ab) begin
      min_d = c_i;
      mid_d = lo_ab;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      mid_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      mid_q <= mid_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign mid_o = mid_q;
  assign min_o = min_q;

endmodule

// File: rtl/rank_filter_3x3.sv
// 3x3 rank-order filter (median/min/max/bypass), 3-cycle pipeline, frame-synchronous mode.
// Optional image-border pass-through is compiled in with RANK_FILTER_BORDER_EN.
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_vsync,
  input  logic                frame_href,
  input  logic                frame_clken,
  input  logic [1:0]          mode,
  input  logic [9*DATA_W-1:0] win_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_vsync,
  output logic                out_href,
  output logic                out_clken,
  output logic [1:0]          active_mode
);

  logic [DATA_W-1:0] pix [9];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pix[i] = win_data[i*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Sync delay line and frame-synchronous mode latch
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0][2:0] ctl_q, ctl_d;
  logic       vs_rise, href_fall;
  rank_mode_e active_mode_q, active_mode_d;
  rank_mode_e mode_s1_q, mode_s2_q;

  assign vs_rise   = frame_vsync & ~ctl_q[0][2];
  assign href_fall = ctl_q[0][1] & ~frame_href;

  always_comb begin
    ctl_d    = ctl_q;
    ctl_d[0] = {frame_vsync, frame_href, frame_clken};
    for (int i = 1; i < PIPE_LAT; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
  end

  // The pixel arriving with the vsync edge already sees the new mode.
  assign active_mode_d = vs_rise ? rank_mode_e'(mode) : active_mode_q;

  // ---------------------------------------------------------------------------
  // Stage 1: sort each window row
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] row_max [3];
  logic [DATA_W-1:0] row_mid [3];
  logic [DATA_W-1:0] row_min [3];

  for (genvar r = 0; r < 3; r++) begin : g_row
    rank_sort3 #(.DATA_W(DATA_W)) u_row_sort (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   (pix[3*r]),
      .b_i   (pix[3*r+1]),
      .c_i   (pix[3*r+2]),
      .max_o (row_max[r]),
      .mid_o (row_mid[r]),
      .min_o (row_min[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sort the row results column-wise
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] max_of_max, min_of_max, mid_of_mid, max_of_min, min_of_min;
  logic [DATA_W-1:0] mid_of_max_unused, max_of_mid_unused;
  logic [DATA_W-1:0] min_of_mid_unused, mid_of_min_unused;

  rank_sort3 #(.DATA_W(DATA_W)) u_sort_max (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (row_max[0]),
    .b_i   (row_max[1]),
    .c_i   (row_max[2]),
    .max_o (max_of_max),
    .mid_o (mid_of_max_unused),
    .min_o (min_of_max)
  );

  rank_sort3 #(.DATA_W(DATA_W)) u_sort_mid (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (row_mid[0]),
    .b_i   (row_mid[1]),
    .c_i   (row_mid[2]),
    .max_o (max_of_mid_unused),
    .mid_o (mid_of_mid),
    .min_o (min_of_mid_unused)
  );

  rank_sort3 #(.DATA_W(DATA_W)) u_sort_min (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (row_min[0]),
    .b_i   (row_min[1]),
    .c_i   (row_min[2]),
    .max_o (max_of_min),
    .mid_o (mid_of_min_unused),
    .min_o (min_of_min)
  );

  // ---------------------------------------------------------------------------
  // Border tracking
  // ---------------------------------------------------------------------------
`ifdef RANK_FILTER_BORDER_EN
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic             border_now, border_s1_q, border_s2_q;

  // Counters saturate so over-long lines/frames keep reporting border.
  always_comb begin
    col_d = col_q;
    if (!frame_href) begin
      col_d = '0;
    end else if (frame_clken && (col_q != COL_LAST)) begin
      col_d = col_q + COL_W'(1);
    end

    row_d = row_q;
    if (vs_rise) begin
      row_d = '0;
    end else if (href_fall && (row_q != ROW_LAST)) begin
      row_d = row_q + ROW_W'(1);
    end
  end

  assign row_cur    = vs_rise ? '0 : row_q;
  assign border_now = (col_q == '0) || (col_q == COL_LAST) ||
                      (row_cur == '0) || (row_cur == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      border_s1_q <= 1'b0;
      border_s2_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      border_s1_q <= border_now;
      border_s2_q <= border_s1_q;
    end
  end
`else
  // Geometry only matters when border tracking is built in.
  localparam int img_area_unused = IMG_W * IMG_H;
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: final median and mode-selected output register
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] hi, lo, res;
    hi  = (a > b) ? a : b;
    lo  = (a > b) ? b : a;
    res = c;
    if (c > hi) res = hi;
    else if (c < lo) res = lo;
    return res;
  endfunction

  logic [DATA_W-1:0] p22_s1_q, p22_s2_q;
  logic [DATA_W-1:0] median_s2, out_data_d, out_data_q;

  assign median_s2 = mid3(min_of_max, mid_of_mid, max_of_min);

  always_comb begin
    out_data_d = median_s2;
    case (mode_s2_q)
      MODE_MIN:    out_data_d = min_of_min;
      MODE_MAX:    out_data_d = max_of_max;
      MODE_BYPASS: out_data_d = p22_s2_q;
      default:     out_data_d = median_s2;
    endcase
`ifdef RANK_FILTER_BORDER_EN
    if (border_s2_q) out_data_d = p22_s2_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q         <= '0;
      active_mode_q <= MODE_MEDIAN;
      mode_s1_q     <= MODE_MEDIAN;
      mode_s2_q     <= MODE_MEDIAN;
      p22_s1_q      <= '0;
      p22_s2_q      <= '0;
      out_data_q    <= '0;
    end else begin
      ctl_q         <= ctl_d;
      active_mode_q <= active_mode_d;
      mode_s1_q     <= active_mode_d;
      mode_s2_q     <= mode_s1_q;
      p22_s1_q      <= pix[4];
      p22_s2_q      <= p22_s1_q;
      out_data_q    <= out_data_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_vsync   = ctl_q[PIPE_LAT-1][2];
  assign out_href    = ctl_q[PIPE_LAT-1][1];
  assign out_clken   = ctl_q[PIPE_LAT-1][0];
  assign active_mode = active_mode_q;

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3: 8-bit and 12-bit instances plus a 4x3 border instance.
module tb_rank_filter_3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, href, clken;
  logic [1:0]  mode;
  logic [11:0] pix [9];
  logic [71:0]  win8;
  logic [107:0] win12;

  logic [7:0]  a_data;  logic a_vs, a_hr, a_ck; logic [1:0] a_mode;
  logic [11:0] c_data;  logic c_vs, c_hr, c_ck; logic [1:0] c_mode;
  logic [7:0]  b_data;  logic b_vs, b_hr, b_ck; logic [1:0] b_mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    win8  = '0;
    win12 = '0;
    for (int i = 0; i < 9; i++) begin
      win8[i*8 +: 8]   = pix[i][7:0];
      win12[i*12 +: 12] = pix[i];
    end
  end

  rank_filter_3x3 #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .frame_vsync(vsync), .frame_href(href),
    .frame_clken(clken), .mode(mode), .win_data(win8), .out_data(a_data),
    .out_vsync(a_vs), .out_href(a_hr), .out_clken(a_ck), .active_mode(a_mode));

  rank_filter_3x3 #(.DATA_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .frame_vsync(vsync), .frame_href(href),
    .frame_clken(clken), .mode(mode), .win_data(win12), .out_data(c_data),
    .out_vsync(c_vs), .out_href(c_hr), .out_clken(c_ck), .active_mode(c_mode));

  rank_filter_3x3 #(.DATA_W(8), .IMG_W(4), .IMG_H(3)) dutb (
    .clk(clk), .rst_n(rst_n), .frame_vsync(vsync), .frame_href(href),
    .frame_clken(clken), .mode(mode), .win_data(win8), .out_data(b_data),
    .out_vsync(b_vs), .out_href(b_hr), .out_clken(b_ck), .active_mode(b_mode));

  // Border-instance output capture
  logic       cap_en = 1'b0;
  int         cap_n;
  logic [7:0] cap [12];
  always @(negedge clk) begin
    if (!cap_en) cap_n = 0;
    else if (b_ck) begin
      if (cap_n < 12) cap[cap_n] = b_data;
      cap_n++;
    end
  end

  typedef struct {
    bit             nf;
    logic [1:0]     mode;
    logic [8:0][7:0] w;
    logic [7:0]     exp;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [8:0][7:0] mkw(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    logic [8:0][7:0] r;
    r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0];
    r[3] = a3[7:0]; r[4] = a4[7:0]; r[5] = a5[7:0];
    r[6] = a6[7:0]; r[7] = a7[7:0]; r[8] = a8[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // vsync pulse with mode m, then one empty line (row 1) and a dummy col-0 pixel.
  task automatic frame_start(input logic [1:0] m);
    @(negedge clk); vsync = 1'b1; mode = m; href = 1'b0; clken = 1'b0;
    @(negedge clk); vsync = 1'b0;
    @(posedge clk); #1 chk("vsync_lat_early", 32'(a_vs), 32'd0);
    @(posedge clk); #1 chk("vsync_lat", 32'(a_vs), 32'd1);
    chk("mode_latch", 32'(a_mode), 32'(m));
    @(negedge clk); href = 1'b1;
    @(negedge clk); href = 1'b0;
    @(negedge clk); href = 1'b1; clken = 1'b1;
    @(negedge clk); clken = 1'b0;
  endtask

  // One clken pulse; returns just after the edge where its result appears.
  task automatic send_pixel(input string nm);
    @(negedge clk); clken = 1'b1;
    @(negedge clk); clken = 1'b0;
    @(posedge clk); #1 chk({nm, "_clken_early"}, 32'(a_ck), 32'd0);
    @(posedge clk); #1 chk({nm, "_clken"}, 32'(a_ck), 32'd1);
    chk({nm, "_href"}, 32'(a_hr), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_mode;
    logic [7:0] exp_b;

    tbl[0]  = '{1'b1, 2'd0, mkw(9,1,8,2,7,3,6,4,5), 8'd5};
    tbl[1]  = '{1'b0, 2'd1, mkw(9,1,8,2,7,3,6,4,5), 8'd5};
    tbl[2]  = '{1'b1, 2'd1, mkw(9,1,8,2,7,3,6,4,5), 8'd1};
    tbl[3]  = '{1'b1, 2'd2, mkw(9,1,8,2,7,3,6,4,5), 8'd9};
    tbl[4]  = '{1'b1, 2'd3, mkw(9,1,8,2,7,3,6,4,5), 8'd7};
    tbl[5]  = '{1'b1, 2'd0, mkw(0,0,0,255,255,255,10,20,30), 8'd20};
    tbl[6]  = '{1'b0, 2'd0, mkw(200,50,125,125,125,125,7,250,3), 8'd125};
    tbl[7]  = '{1'b1, 2'd1, mkw(200,50,125,125,125,125,7,250,3), 8'd3};
    tbl[8]  = '{1'b0, 2'd2, mkw(200,50,125,125,125,125,7,250,3), 8'd3};
    tbl[9]  = '{1'b1, 2'd2, mkw(200,50,125,125,125,125,7,250,3), 8'd250};
    tbl[10] = '{1'b1, 2'd3, mkw(1,2,3,4,77,6,7,8,9), 8'd77};
    tbl[11] = '{1'b0, 2'd0, mkw(1,2,3,4,77,6,7,8,9), 8'd77};
    tbl[12] = '{1'b1, 2'd0, mkw(42,42,42,42,42,42,42,42,42), 8'd42};
    tbl[13] = '{1'b1, 2'd2, mkw(0,0,0,255,255,255,10,20,30), 8'd255};

    // Reset with busy inputs: outputs must hold zero.
    rst_n = 1'b0; vsync = 1'b1; href = 1'b1; clken = 1'b1; mode = 2'd3;
    for (int i = 0; i < 9; i++) pix[i] = 12'hABC;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_clken", 32'(a_ck), 32'd0);
    chk("rst_vsync", 32'(a_vs), 32'd0);
    chk("rst_href", 32'(a_hr), 32'd0);
    chk("rst_mode", 32'(a_mode), 32'd0);
    chk("rst_data12", 32'(c_data), 32'd0);
    vsync = 1'b0; href = 1'b0; clken = 1'b0; mode = 2'd0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    exp_mode = 2'd0;
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].nf) begin
        frame_start(tbl[k].mode);
        exp_mode = tbl[k].mode;
      end else begin
        mode = tbl[k].mode;
      end
      for (int i = 0; i < 9; i++) pix[i] = {4'h0, tbl[k].w[i]};
      send_pixel($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_data", k), 32'(a_data), 32'(tbl[k].exp));
      chk($sformatf("vec%0d_mode", k), 32'(a_mode), 32'(exp_mode));
    end

    // Reset while a max-mode pixel is in flight.
    frame_start(2'd2);
    pix[0] = 12'd9; pix[1] = 12'd1; pix[2] = 12'd8; pix[3] = 12'd2; pix[4] = 12'd7;
    pix[5] = 12'd3; pix[6] = 12'd6; pix[7] = 12'd4; pix[8] = 12'd5;
    @(negedge clk); clken = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(a_data), 32'd0);
    chk("midrst_clken", 32'(a_ck), 32'd0);
    chk("midrst_href", 32'(a_hr), 32'd0);
    chk("midrst_vsync", 32'(a_vs), 32'd0);
    chk("midrst_mode", 32'(a_mode), 32'd0);
    @(negedge clk); clken = 1'b0; rst_n = 1'b1;
    pix[4] = 12'd5; pix[8] = 12'd7;
    send_pixel("resume");
    chk("resume_data", 32'(a_data), 32'd5);
    chk("resume_mode", 32'(a_mode), 32'd0);

    // DATA_W=12: all 0xFFF except dark centre.
    frame_start(2'd0);
    for (int i = 0; i < 9; i++) pix[i] = 12'hFFF;
    pix[4] = 12'h000;
    send_pixel("w12_med");
    chk("w12_med_data", 32'(c_data), 32'hFFF);
    chk("w8_med_data", 32'(a_data), 32'hFF);
    frame_start(2'd1);
    send_pixel("w12_min");
    chk("w12_min_data", 32'(c_data), 32'h000);
    chk("w8_min_data", 32'(a_data), 32'h00);

    // 4x3 frame on the border instance, centre 100 and zero elsewhere.
    for (int i = 0; i < 9; i++) pix[i] = 12'd0;
    pix[4] = 12'd100;
    @(negedge clk); href = 1'b0; clken = 1'b0;
    @(negedge clk); cap_en = 1'b1; vsync = 1'b1; mode = 2'd0;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk); href = 1'b1; clken = 1'b1;
      end
      @(negedge clk); href = 1'b0; clken = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    cap_en = 1'b0;
    chk("border_count", 32'(cap_n), 32'd12);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef RANK_FILTER_BORDER_EN
        exp_b = (r == 0 || r == 2 || c == 0 || c == 3) ? 8'd100 : 8'd0;
`else
        exp_b = 8'd0;
`endif
        chk($sformatf("border_r%0d_c%0d", r, c), 32'(cap[r*4+c]), 32'(exp_b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rank_filter_3x3.md
# rank_filter_3x3

Parametrised 3x3 rank-order filter for the HumanDetector video path; successor to the fixed 8-bit median stage. Takes a 3x3 window from the upstream line-buffer/matrix generator and outputs, per pixel, the median, minimum (erosion), maximum (dilation) or unfiltered centre value. Mode is frame-synchronous, data width is generic, and image-border pixels can pass through unfiltered. Sits between the window generator and the binarisation/morphology stages.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits (1..16)
- IMG_W, 640, active pixels per line (border detection)
- IMG_H, 480, active lines per frame (border detection)

Ports:
- clk  in  1  pixel clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_vsync  in  1  input vsync, active high
- frame_href  in  1  input line valid
- frame_clken  in  1  input pixel valid
- mode  in  2  requested mode: 0 median, 1 min, 2 max, 3 bypass
- win_data  in  9*DATA_W  window, P11 at [DATA_W-1:0], row-major, P33 at top; P22 = centre
- out_data  out  DATA_W  filtered pixel
- out_vsync  out  1  frame_vsync delayed 3 cycles
- out_href  out  1  frame_href delayed 3 cycles
- out_clken  out  1  frame_clken delayed 3 cycles
- active_mode  out  2  mode currently in force

## Operation
- Stage 1: each window row sorted into max/mid/min (three rank_sort3 instances).
- Stage 2: max-of-row-maxes, min-of-row-mins, min-of-maxes, mid-of-mids, max-of-mins.
- Stage 3: median = mid(min-of-maxes, mid-of-mids, max-of-mins); min = min-of-mins; max = max-of-maxes; bypass = P22 delayed 3. Output register selects by active_mode.
- Comparisons unsigned, DATA_W wide; no widening, no rounding.
- Mode latch: active_mode <= mode on rising edge of frame_vsync (detected vs. registered previous vsync); held for the whole frame. Mode changes mid-frame are ignored until next vsync rising edge. After reset active_mode = 0 (median) until first vsync edge.
- Selection uses active_mode pipelined with the data, so a pixel is always filtered with the mode valid when it entered.
- Pipeline is free-running: out_data updates every cycle; only meaningful when out_clken = 1. No backpressure.
- Border tracking (when compiled in): col counter increments on frame_href & frame_clken, clears when frame_href = 0; row counter increments on frame_href falling edge, clears on frame_vsync rising edge. Pixel is border if col = 0, col = IMG_W-1, row = 0 or row = IMG_H-1. Border flag pipelined 3 stages; border pixel outputs delayed P22 regardless of mode. Counters saturate at IMG_W-1 / IMG_H-1 (over-long lines/frames stay border).

## Timing
- Latency: exactly 3 cycles from input to out_data/out_*, all modes.
- Throughput: one pixel per cycle, back-to-back clken permitted.
- Reset: out_data = 0, out_vsync/out_href/out_clken = 0, active_mode = 0, counters = 0, all pipeline registers 0. Reset mid-frame discards in-flight pixels; first valid output is 3 cycles after first clken following release.
- vsync edge and clken in same cycle: pixel uses the newly latched mode; row counter clears in that cycle.
- href falling and vsync rising same cycle: clear wins.

## Configuration
- RANK_FILTER_BORDER_EN defined: counters and border pass-through as above; IMG_W/IMG_H used.
- Not defined: no counters, no border flag; every pixel filtered per active_mode; IMG_W/IMG_H unused.

## Structure
- Package rank_filter_pkg: mode encodings (MODE_MEDIAN=0, MODE_MIN=1, MODE_MAX=2, MODE_BYPASS=3), PIPE_LAT=3.
- Sub-module rank_sort3 (parameter DATA_W): registered 3-input sorter, outputs max/mid/min, 1-cycle latency, async active-low reset to 0. Stage 2 reuses it; stage 3 output mux is local.

## Test plan
- Median, DATA_W=8: window {9,1,8,2,7,3,6,4,5} with clken pulse -> out_data = 5 and out_clken = 1 exactly 3 cycles later.
- Mode latch: mode=1 set mid-frame -> output stays median; after vsync rising edge, same window -> out_data = 1; mode=2 next frame -> 9; mode=3 -> centre 7.
- DATA_W=12: window all 0xFFF except P22=0x000, median mode -> 0xFFF; min mode -> 0x000.
- Border (macro on, IMG_W=4, IMG_H=3): 4x3 frame of windows with centre 100, all others 0, median mode -> 100 on all rows 0/2 and cols 0/3, 0 on interior pixels (1,1),(1,2).
- Macro off, same frame -> 0 on every pixel.
- Reset mid-frame with clken active -> all outputs 0 next cycle, active_mode = 0; stream resumes with 3-cycle latency.
